adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
Shares one registered WIDTH-bit adder (the ADDER10 datapath) between two requesters. Each requester presents an operand pair with a valid/ready handshake. The block arbitrates between them, drives the adder inputs, waits out the adder latency, and returns the sum on a single response channel tagged with the requester ID. One operation is in flight at a time.

Parameters:
WIDTH, 10, operand width; the adder output is WIDTH+1 bits.
LATENCY, 1, clock edges from a stable adder input to a valid add_out; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req1_valid  input  1  requester 1 has an operand pair
req1_ready  output  1  requester 1 accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
add_in1  output  WIDTH  to adder in1
add_in2  output  WIDTH  to adder in2
add_out  input  WIDTH+1  from adder out
rsp_valid  output  1  response available
rsp_id  output  1  requester that owns the response
rsp_data  output  WIDTH+1  sum
rsp_ready  input  1  consumer accepts the response
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, cnt=0, prio=0 (req0 preferred). add_in1, add_in2, rsp_data, rsp_id, rsp_valid, req*_ready and busy are all 0. A reset mid-operation drops the in-flight operation; no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational and asserts only for the arbitration winner among the valid requesters. At most one ready is high.
  - Handshake = valid & ready in the same cycle (cycle T).
  - At T's edge: latch a/b into operand registers, set rsp_id=N, cnt=0, go to WAIT.
  - No valid requester: stay in IDLE.
- WAIT:
  - add_in1/add_in2 come from the operand registers (valid from T+1) and stay held until the next accept.
  - cnt increments each cycle.
  - When cnt==LATENCY, sample add_out into rsp_data and go to RESP.
  - With LATENCY=1, sampling happens in T+2.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data are held stable.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid deasserts the next cycle.
  - No ready asserts in RESP or WAIT.
- Latency: accept at T, rsp_valid first high at T+LATENCY+2. Minimum issue interval is LATENCY+3 cycles.
- Arbitration (default is round-robin):
  - Both valid: grant requester prio, then set prio to the other requester.
  - One valid: grant it, and set prio to the other requester.
- Requester rules: a/b must be stable while valid is high and not yet accepted. Valid may drop without a handshake; this has no effect.
- Arithmetic: rsp_data = add_out, unsigned, WIDTH+1 bits, no truncation (max 2*(2^WIDTH-1)).
- Simultaneous rst with any handshake: reset wins.

Optional Feature:
ADDER_ARB_FIXED_PRIO_EN
- Defined: fixed priority, req0 always wins when both are valid. The prio register is removed.
- Undefined: round-robin as specified above.
- Timing and the handshake are identical in both builds.

Test Plan:
1. Hold rst=1 for 5 cycles with both valids high -> both readys 0, rsp_valid 0, busy 0, add_in1/add_in2 0. After rst=0, req0 is granted first (prio=0).
2. req0 a=10 b=20 alone, LATENCY=1, rsp_ready=1 -> req0_ready at T; rsp_valid at T+3 for one cycle with rsp_id=0, rsp_data=30; busy high T+1..T+3.
3. Both valid continuously, req0 123+456, req1 1023+1023 -> grants alternate 0,1,0,1; rsp_data 579, 2046, 579. With ADDER_ARB_FIXED_PRIO_EN defined -> only req0 granted, all results 579.
4. rsp_ready held 0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable; no ready asserted; busy=1. The handshake completes on the cycle rsp_ready rises, and the state returns to IDLE.
5. rst pulsed for 1 cycle during WAIT -> next cycle IDLE, outputs 0. No response ever appears for the dropped operation.
6. Instantiate with LATENCY=3 and an adder model of 3-cycle delay, req1 7+8 -> rsp_valid at T+5, rsp_id=1, rsp_data=15.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester front end for one shared registered adder.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default round-robin.
module adder_arbiter #(
  parameter int WIDTH   = 10,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] add_in1,
  output logic [WIDTH-1:0] add_in2,
  input  logic [WIDTH:0]   add_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t     state;
  logic [3:0] cnt;
  logic       gnt0;
  logic       gnt1;
  logic       idle_ok;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`else
  logic prio;

  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~prio);
    gnt1 = req1_valid & (~req0_valid | prio);
  end
`endif

  // Reset masks the grant so no handshake can slip through with rst high.
  assign idle_ok    = (state == IDLE) & ~rst;
  assign req0_ready = idle_ok & gnt0;
  assign req1_ready = idle_ok & gnt1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      add_in1  <= '0;
      add_in2  <= '0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      prio     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            add_in1 <= req1_ready ? req1_a : req0_a;
            add_in2 <= req1_ready ? req1_b : req0_b;
            rsp_id  <= req1_ready;
            cnt     <= '0;
            state   <= WAIT;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            prio    <= req0_ready;
`endif
          end
        end
        WAIT: begin
          if (cnt == LAT) begin
            rsp_data <= add_out;
            state    <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: timeline reference model plus directed and random stimulus.
// Second instance exercises a three-cycle adder.
module tb_adder_arbiter;
  localparam int W = 10;
  localparam int L = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic         rst = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         rrdy = 1'b0;
  logic         r0, r1, rv, rid, bsy;
  logic [W-1:0] in1, in2;
  logic [W:0]   rdata, aout;

  adder_arbiter #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
    .add_in1(in1), .add_in2(in2), .add_out(aout),
    .rsp_valid(rv), .rsp_id(rid), .rsp_data(rdata),
    .rsp_ready(rrdy), .busy(bsy)
  );

  always @(posedge clk) aout <= {1'b0, in1} + {1'b0, in2};

  logic         rst3 = 1'b1;
  logic         v0_3 = 1'b0, v1_3 = 1'b0;
  logic [W-1:0] a1_3 = '0, b1_3 = '0, z3 = '0;
  logic         rrdy3 = 1'b1;
  logic         r0_3, r1_3, rv3, rid3, bsy3;
  logic [W-1:0] in1_3, in2_3;
  logic [W:0]   rdata3, aout3;
  logic [W:0]   pipe3 [3];

  adder_arbiter #(.WIDTH(W), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3),
    .req0_valid(v0_3), .req0_ready(r0_3), .req0_a(z3), .req0_b(z3),
    .req1_valid(v1_3), .req1_ready(r1_3), .req1_a(a1_3), .req1_b(b1_3),
    .add_in1(in1_3), .add_in2(in2_3), .add_out(aout3),
    .rsp_valid(rv3), .rsp_id(rid3), .rsp_data(rdata3),
    .rsp_ready(rrdy3), .busy(bsy3)
  );

  always @(posedge clk) begin
    pipe3[0] <= {1'b0, in1_3} + {1'b0, in2_3};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign aout3 = pipe3[2];

  // Reference: an accepted op owns the adder from accept cycle t;
  // the response is visible from t+L+2 until the consumer takes it.
  int           cyc = 0;
  bit           started = 0;
  bit           m_busy = 0;
  int           m_t = 0;
  bit           m_id = 0;
  bit           m_prio = 0;
  logic [W:0]   m_sum = '0;
  logic [W-1:0] m_in1 = '0, m_in2 = '0;
  bit           hs0 = 0, hs1 = 0;

  function automatic bit win1(bit x0, bit x1, bit p);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    return x1 && !x0;
`else
    return x1 && (!x0 || p);
`endif
  endfunction

  always @(posedge clk) begin
    bit g;
    hs0 = 0;
    hs1 = 0;
    if (rst) begin
      m_busy = 0; m_id = 0; m_prio = 0;
      m_in1 = '0; m_in2 = '0;
    end else if (!m_busy) begin
      if (v0 || v1) begin
        g = win1(v0, v1, m_prio);
        hs0 = !g;
        hs1 = g;
        m_busy = 1;
        m_t = cyc;
        m_id = g;
        m_in1 = g ? a1 : a0;
        m_in2 = g ? b1 : b0;
        m_sum = {1'b0, m_in1} + {1'b0, m_in2};
        m_prio = !g;
      end
    end else if (cyc >= m_t + L + 2 && rrdy) begin
      m_busy = 0;
    end
    cyc++;
    started = 1;
  end

  always @(negedge clk) begin
    bit e0, e1, ev;
    if (started) begin
      if (!m_busy) begin
        e1 = !rst && win1(v0, v1, m_prio);
        e0 = !rst && v0 && !win1(v0, v1, m_prio);
        ev = 0;
      end else begin
        e0 = 0;
        e1 = 0;
        ev = (cyc >= m_t + L + 2);
      end
      chk("req0_ready", r0, e0);
      chk("req1_ready", r1, e1);
      chk("rsp_valid", rv, ev);
      chk("busy", bsy, m_busy);
      chk("add_in1", in1, m_in1);
      chk("add_in2", in2, m_in2);
      chk("rsp_id", rid, m_id);
      if (ev) chk("rsp_data", rdata, m_sum);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom % 4)
      0: return '0;
      1: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gq[$];
    int dq[$];
    int lat;
    bit seen;

    v0 = 1; a0 = 10'd123; b0 = 10'd456;
    v1 = 1; a1 = 10'd1023; b1 = 10'd1023;
    rrdy = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("t1_ready0", r0, 0);
      chk("t1_ready1", r1, 0);
      chk("t1_rsp_valid", rv, 0);
      chk("t1_busy", bsy, 0);
      chk("t1_add_in1", in1, 0);
      chk("t1_add_in2", in2, 0);
      chk("t1_rsp_data", rdata, 0);
    end
    step();
    rst = 0;

    for (int i = 0; i < 60 && dq.size() < 4; i++) begin
      @(negedge clk);
      if (r0) gq.push_back(0);
      if (r1) gq.push_back(1);
      if (rv && rrdy) dq.push_back(int'(rdata));
      step();
    end
    v0 = 0;
    v1 = 0;
    chk("t3_grants", gq.size() >= 4, 1);
    chk("t3_results", dq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size() && i < dq.size(); i++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      chk("t3_grant", gq[i], 0);
      chk("t3_sum", dq[i], 579);
`else
      chk("t3_grant", gq[i], i % 2);
      chk("t3_sum", dq[i], (i % 2) ? 2046 : 579);
`endif
    end
    for (int i = 0; i < 20 && bsy; i++) step();

    v0 = 1; a0 = 10'd10; b0 = 10'd20; rrdy = 1;
    @(negedge clk);
    chk("t2_ready0", r0, 1);
    step();
    v0 = 0;
    @(negedge clk);
    chk("t2_busy1", bsy, 1);
    chk("t2_valid1", rv, 0);
    step();
    @(negedge clk);
    chk("t2_busy2", bsy, 1);
    chk("t2_valid2", rv, 0);
    step();
    @(negedge clk);
    chk("t2_valid3", rv, 1);
    chk("t2_id", rid, 0);
    chk("t2_sum", rdata, 30);
    chk("t2_busy3", bsy, 1);
    step();
    @(negedge clk);
    chk("t2_valid4", rv, 0);
    chk("t2_busy4", bsy, 0);

    step();
    v1 = 1; a1 = 10'd5; b1 = 10'd6; rrdy = 0;
    @(negedge clk);
    chk("t4_ready1", r1, 1);
    step();
    v1 = 0;
    v0 = 1; a0 = 10'd1; b0 = 10'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv) break;
      step();
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_valid", rv, 1);
      chk("t4_id", rid, 1);
      chk("t4_sum", rdata, 11);
      chk("t4_ready0", r0, 0);
      chk("t4_busy", bsy, 1);
      step();
    end
    rrdy = 1;
    @(negedge clk);
    chk("t4_release", rv, 1);
    step();
    v0 = 0;
    @(negedge clk);
    chk("t4_after_valid", rv, 0);
    chk("t4_after_busy", bsy, 0);

    step();
    v0 = 1; a0 = 10'd100; b0 = 10'd200;
    @(negedge clk);
    chk("t5_ready0", r0, 1);
    step();
    v0 = 0;
    rst = 1;
    @(negedge clk);
    chk("t5_busy_wait", bsy, 1);
    step();
    rst = 0;
    @(negedge clk);
    chk("t5_busy", bsy, 0);
    chk("t5_add_in1", in1, 0);
    chk("t5_add_in2", in2, 0);
    chk("t5_valid", rv, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (rv) seen = 1;
    end
    chk("t5_no_rsp", seen, 0);

    for (int i = 0; i < 3000; i++) begin
      step();
      if (hs0 || !v0) begin a0 = rnd(); b0 = rnd(); end
      if (hs1 || !v1) begin a1 = rnd(); b1 = rnd(); end
      v0 = ($urandom % 4) != 0;
      v1 = ($urandom % 3) != 0;
      rrdy = $urandom % 2;
      rst = ($urandom % 120) == 0;
    end
    step();
    v0 = 0; v1 = 0; rst = 0; rrdy = 1;
    for (int i = 0; i < 10; i++) step();

    step();
    rst3 = 0;
    step();
    v1_3 = 1; a1_3 = 10'd7; b1_3 = 10'd8; rrdy3 = 1;
    @(negedge clk);
    chk("t6_ready1", r1_3, 1);
    chk("t6_ready0", r0_3, 0);
    step();
    v1_3 = 0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rv3) begin
        lat = n;
        break;
      end
      step();
    end
    chk("t6_latency", lat, 5);
    chk("t6_id", rid3, 1);
    chk("t6_sum", rdata3, 15);
    step();
    @(negedge clk);
    chk("t6_valid_drop", rv3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
